rgb_pwm_sequencer: RTL and testbench

//   Parametrised LED colour sequencer driving a CHANNELS-wide one-hot LED bus.
//   The raw pushbutton input is synchronised and debounced, and each accepted

---
 rtl/rgb_pwm_sequencer.sv | 151 +++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - debounced button-stepped one-hot LED channel sequencer with PWM dimming
// Synchroniser, debouncer, STEP/STEP_REV/AUTO/HOLD channel sequencing and registered PWM-gated rgb drive.
module rgb_pwm_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        button,
  input  logic [1:0]                  mode,
  input  logic [PWM_BITS-1:0]         duty,
  output logic [CHANNELS-1:0]         rgb,
  output logic [$clog2(CHANNELS)-1:0] channel,
  output logic                        step_pulse
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int AT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_STEP     = 2'b00,
    MODE_STEP_REV = 2'b01,
    MODE_AUTO     = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  mode_e mode_s;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                deb_q, deb_d;
  logic                deb_prev_q, deb_prev_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [AT_W-1:0]     timer_q, timer_d;
  logic [CH_W-1:0]     channel_q, channel_d;
  logic                step_pulse_q, step_pulse_d;
  logic [CHANNELS-1:0] rgb_q, rgb_d;

  logic            press;
  logic            pwm_on;
  logic [CH_W-1:0] ch_inc;
  logic [CH_W-1:0] ch_dec;

  assign mode_s = mode_e'(mode);

  // Debounced level only toggles after DEBOUNCE_CYCLES unbroken mismatch cycles.
  always_comb begin
    sync1_d    = button;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    db_cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  assign ch_inc = (channel_q == LAST_CH) ? '0 : channel_q + CH_W'(1);
  assign ch_dec = (channel_q == '0) ? LAST_CH : channel_q - CH_W'(1);

  always_comb begin
    channel_d    = channel_q;
    timer_d      = '0;
    step_pulse_d = 1'b0;
    case (mode_s)
      MODE_STEP: begin
        if (press) begin
          channel_d    = ch_inc;
          step_pulse_d = 1'b1;
        end
      end
      MODE_STEP_REV: begin
        if (press) begin
          channel_d    = ch_dec;
          step_pulse_d = 1'b1;
        end
      end
      MODE_AUTO: begin
        // A press coinciding with terminal count still yields a single advance.
        if (press || (timer_q == AT_LAST)) begin
          channel_d    = ch_inc;
          step_pulse_d = 1'b1;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + AT_W'(1);
        end
      end
      MODE_HOLD: begin
        channel_d = channel_q;
      end
      default: begin
        channel_d = channel_q;
      end
    endcase
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (&duty) | (pwm_cnt_q < duty);
    rgb_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rgb_d[i] = ena & pwm_on & (channel_q == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
      pwm_cnt_q    <= '0;
      timer_q      <= '0;
      channel_q    <= '0;
      step_pulse_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      db_cnt_q     <= db_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      timer_q      <= timer_d;
      channel_q    <= channel_d;
      step_pulse_q <= step_pulse_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb        = rgb_q;
  assign channel    = channel_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb/tb_rgb_pwm_sequencer.sv - directed self-checking bench for rgb_pwm_sequencer
// Small parameter set: 3 channels, 4-bit PWM, 4-cycle debounce, 8-cycle auto period.
module tb_rgb_pwm_sequencer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       button;
  logic [1:0] mode;
  logic [3:0] duty;
  logic [2:0] rgb;
  logic [1:0] channel;
  logic       step_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int p, nz, hits, others;

  rgb_pwm_sequencer #(
    .CHANNELS(3),
    .PWM_BITS(4),
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .button(button),
    .mode(mode),
    .duty(duty),
    .rgb(rgb),
    .channel(channel),
    .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_press(output int pulses, output int nonzero);
    pulses  = 0;
    nonzero = 0;
    button  = 1'b1;
    repeat (8) begin
      tick();
      if (step_pulse) pulses++;
      if (rgb != 3'b000) nonzero++;
    end
    button = 1'b0;
    repeat (8) begin
      tick();
      if (step_pulse) pulses++;
      if (rgb != 3'b000) nonzero++;
    end
  endtask

  task automatic sample16(input logic [2:0] want, output int h, output int o);
    h = 0;
    o = 0;
    repeat (16) begin
      tick();
      if (rgb == want) h++;
      else if (rgb != 3'b000) o++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    button = 1'b1;
    mode   = 2'b00;
    duty   = 4'hF;
    tick();
    tick();
    check("reset_channel", 32'(channel), 0);
    check("reset_rgb", 32'(rgb), 0);
    check("reset_step_pulse", 32'(step_pulse), 0);

    // 1. held button from the first non-reset cycle: channel steps at edge 7
    rst = 1'b0;
    repeat (6) tick();
    check("held_edge6_channel", 32'(channel), 0);
    check("held_edge6_pulse", 32'(step_pulse), 0);
    tick();
    check("held_edge7_channel", 32'(channel), 1);
    check("held_edge7_pulse", 32'(step_pulse), 1);
    check("held_edge7_rgb_old", 32'(rgb), 32'b001);
    tick();
    check("held_edge8_pulse", 32'(step_pulse), 0);
    check("held_edge8_rgb", 32'(rgb), 32'b010);
    button = 1'b0;
    repeat (10) tick();
    check("release_no_step", 32'(channel), 1);
    do_press(p, nz);
    check("step_to_2", 32'(channel), 2);
    check("step_to_2_pulses", 32'(p), 1);
    do_press(p, nz);
    check("step_wrap_0", 32'(channel), 0);
    check("step_wrap_pulses", 32'(p), 1);

    // 2. reverse and hold
    mode = 2'b01;
    do_press(p, nz);
    check("rev_wrap_2", 32'(channel), 2);
    check("rev_pulses", 32'(p), 1);
    mode = 2'b11;
    do_press(p, nz);
    check("hold_press1_channel", 32'(channel), 2);
    check("hold_press1_pulses", 32'(p), 0);
    do_press(p, nz);
    check("hold_press2_channel", 32'(channel), 2);
    check("hold_press2_pulses", 32'(p), 0);

    // 3. 3-cycle glitches are filtered; a 5-cycle pulse steps once
    mode = 2'b00;
    p = 0;
    repeat (4) begin
      button = 1'b1;
      repeat (3) begin tick(); if (step_pulse) p++; end
      button = 1'b0;
      repeat (3) begin tick(); if (step_pulse) p++; end
    end
    repeat (6) begin tick(); if (step_pulse) p++; end
    check("glitch_channel", 32'(channel), 2);
    check("glitch_pulses", 32'(p), 0);
    p = 0;
    button = 1'b1;
    repeat (5) begin tick(); if (step_pulse) p++; end
    button = 1'b0;
    repeat (10) begin tick(); if (step_pulse) p++; end
    check("pulse5_channel", 32'(channel), 0);
    check("pulse5_pulses", 32'(p), 1);

    // 4. auto advance every 8 cycles, press on terminal count gives one advance
    mode = 2'b10;
    repeat (7) tick();
    check("auto_e7", 32'(channel), 0);
    tick();
    check("auto_e8", 32'(channel), 1);
    check("auto_e8_pulse", 32'(step_pulse), 1);
    repeat (8) tick();
    check("auto_e16", 32'(channel), 2);
    repeat (8) tick();
    check("auto_e24_wrap", 32'(channel), 0);
    tick();
    button = 1'b1;
    repeat (6) tick();
    check("auto_e31", 32'(channel), 0);
    tick();
    check("auto_tc_press_single", 32'(channel), 1);
    check("auto_tc_press_pulse", 32'(step_pulse), 1);
    repeat (7) tick();
    check("auto_e39", 32'(channel), 1);
    tick();
    check("auto_e40", 32'(channel), 2);
    mode = 2'b11;
    button = 1'b0;
    repeat (10) tick();
    check("hold_after_auto", 32'(channel), 2);

    // 5. PWM duty and output enable
    duty = 4'd4;
    tick();
    sample16(3'b100, hits, others);
    check("duty4_on_cycles", 32'(hits), 4);
    check("duty4_other", 32'(others), 0);
    duty = 4'd0;
    tick();
    sample16(3'b100, hits, others);
    check("duty0_on_cycles", 32'(hits), 0);
    check("duty0_other", 32'(others), 0);
    duty = 4'hF;
    tick();
    sample16(3'b100, hits, others);
    check("dutyF_on_cycles", 32'(hits), 16);
    check("dutyF_other", 32'(others), 0);
    mode = 2'b00;
    ena = 1'b0;
    tick();
    check("ena0_rgb", 32'(rgb), 0);
    do_press(p, nz);
    check("ena0_channel", 32'(channel), 0);
    check("ena0_pulses", 32'(p), 1);
    check("ena0_rgb_nonzero", 32'(nz), 0);
    ena = 1'b1;

    // 6. reset during debounce and during auto mid-period
    do_press(p, nz);
    check("pre_rst_channel", 32'(channel), 1);
    button = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rst_db_channel", 32'(channel), 0);
    check("rst_db_rgb", 32'(rgb), 0);
    check("rst_db_pulse", 32'(step_pulse), 0);
    rst = 1'b0;
    repeat (6) tick();
    check("rst_db_e6", 32'(channel), 0);
    tick();
    check("rst_db_e7", 32'(channel), 1);
    check("rst_db_e7_pulse", 32'(step_pulse), 1);
    button = 1'b0;
    repeat (10) tick();
    mode = 2'b10;
    repeat (5) tick();
    check("auto_mid_channel", 32'(channel), 1);
    rst = 1'b1;
    tick();
    check("rst_auto_channel", 32'(channel), 0);
    check("rst_auto_rgb", 32'(rgb), 0);
    check("rst_auto_pulse", 32'(step_pulse), 0);
    rst = 1'b0;
    repeat (7) tick();
    check("rst_auto_e7", 32'(channel), 0);
    tick();
    check("rst_auto_e8", 32'(channel), 1);
    check("rst_auto_e8_pulse", 32'(step_pulse), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
